// File: rtl/adc_channel_conditioner.sv
// ---------------------------------------------------------------------------
// adc_channel_conditioner
//
// Receive front-end conditioner for one 12-bit ADC channel. The raw sample is
// registered, widened to 16 bits (scaled by 8) and a DC offset is removed.
// The offset comes from a 32-bit closed-loop integrator that accumulates the
// corrected output while the DC loop is enabled. The integrator can also be
// loaded directly over the serial settings bus. In parallel, two leaky
// averagers produce an RSSI (mean magnitude) estimate and an over-range
// (clip) density estimate for AGC.
//
// Ports:
//   clock          system clock, all state updates on the rising edge
//   reset          asynchronous, active-high, clears all state
//   enable         run enable for RSSI / over-range; low clears both
//   serial_addr    settings-bus address (7 bits)
//   serial_data    settings-bus data (32 bits)
//   serial_strobe  settings-bus write strobe, one cycle
//   adc_raw        two's-complement 12-bit ADC sample
//   adc_corr       16-bit DC-corrected sample (wrapping arithmetic)
//   rssi           16-bit smoothed magnitude estimate
//   over_count     16-bit smoothed over-range density
//   dco_en_reg     contents of the 32-bit DC-loop enable register
// ---------------------------------------------------------------------------
module adc_channel_conditioner #(
    parameter logic [6:0] ADDR_DCO_EN = 7'd10,
    parameter logic [6:0] ADDR_OFFSET = 7'd11,
    parameter int         DCO_BIT     = 0
) (
    input  logic        clock,
    input  logic        reset,
    input  logic        enable,
    input  logic [6:0]  serial_addr,
    input  logic [31:0] serial_data,
    input  logic        serial_strobe,
    input  logic [11:0] adc_raw,
    output logic [15:0] adc_corr,
    output logic [15:0] rssi,
    output logic [15:0] over_count,
    output logic [31:0] dco_en_reg
);

    // -----------------------------------------------------------------------
    // State
    // -----------------------------------------------------------------------
    logic [11:0] adc_q_reg;
    logic [31:0] integrator_reg;
    logic [31:0] integrator_next;
    logic [31:0] dco_en_next;
    logic [25:0] rssi_int_reg;
    logic [25:0] rssi_int_next;
    logic [25:0] over_int_reg;
    logic [25:0] over_int_next;

    // -----------------------------------------------------------------------
    // Settings-bus decode
    // -----------------------------------------------------------------------
    logic wr_dco_en;
    logic wr_offset;
    logic dco_en;

    assign wr_dco_en = serial_strobe && (serial_addr == ADDR_DCO_EN);
    assign wr_offset = serial_strobe && (serial_addr == ADDR_OFFSET);
    assign dco_en    = dco_en_reg[DCO_BIT];

    assign dco_en_next = wr_dco_en ? serial_data : dco_en_reg;

    // -----------------------------------------------------------------------
    // DC correction path
    // -----------------------------------------------------------------------
    logic [15:0] x_wide;
    logic [15:0] scaled;
    logic        round_up;

    // Sign-extend by one bit and scale by 8 so the sample sits in the upper
    // part of the 16-bit word, leaving headroom below for the offset.
    assign x_wide = {adc_q_reg[11], adc_q_reg, 3'b000};

    // Taking the top half of a negative integrator would round toward minus
    // infinity; adding one when any fraction bit is set rounds toward zero,
    // which keeps the loop symmetric around the origin.
    assign round_up = integrator_reg[31] & (|integrator_reg[15:0]);
    assign scaled   = integrator_reg[31:16] + {15'd0, round_up};

    assign adc_corr = x_wide - scaled;

    always_comb begin
        integrator_next = integrator_reg;
        if (wr_offset) begin
            // A bus load takes priority over accumulation in the same cycle.
            integrator_next = {serial_data[15:0], 16'h0000};
        end else if (dco_en) begin
            integrator_next = integrator_reg + {{16{adc_corr[15]}}, adc_corr};
        end
    end

    // -----------------------------------------------------------------------
    // RSSI path
    // -----------------------------------------------------------------------
    // Ones'-complement magnitude: invert every bit of a negative sample. This
    // avoids a carry chain and maps -2048 to 2047 so it never overflows.
    logic [11:0] mag;

    genvar gi;
    generate
        for (gi = 0; gi < 12; gi++) begin : g_mag
            assign mag[gi] = adc_q_reg[gi] ^ adc_q_reg[11];
        end
    endgenerate

    // Leaky integrator: the accumulator holds roughly 1024x the mean input,
    // so the top 16 bits read back as the average itself.
    always_comb begin
        rssi_int_next = '0;
        if (enable) begin
            rssi_int_next = rssi_int_reg + {14'd0, mag} - {10'd0, rssi_int_reg[25:10]};
        end
    end

    assign rssi = rssi_int_reg[25:10];

    // -----------------------------------------------------------------------
    // Over-range path
    // -----------------------------------------------------------------------
    logic        over;
    logic [25:0] over_in;

    assign over    = (adc_q_reg == 12'h7FF) || (adc_q_reg == 12'h800);
    assign over_in = over ? 26'd65535 : 26'd0;

    // Same leaky structure as RSSI with a full-scale input of 65535. The
    // fixed point is 65535 * 1024, just under 2^26, so the sum cannot wrap.
    always_comb begin
        over_int_next = '0;
        if (enable) begin
            over_int_next = over_int_reg + over_in - {10'd0, over_int_reg[25:10]};
        end
    end

    assign over_count = over_int_reg[25:10];

    // -----------------------------------------------------------------------
    // Registers
    // -----------------------------------------------------------------------
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            adc_q_reg      <= '0;
            dco_en_reg     <= '0;
            integrator_reg <= '0;
            rssi_int_reg   <= '0;
            over_int_reg   <= '0;
        end else begin
            adc_q_reg      <= adc_raw;
            dco_en_reg     <= dco_en_next;
            integrator_reg <= integrator_next;
            rssi_int_reg   <= rssi_int_next;
            over_int_reg   <= over_int_next;
        end
    end

endmodule

// File: tb/tb_adc_channel_conditioner.sv
// ---------------------------------------------------------------------------
// Testbench for adc_channel_conditioner.
//
// A stimulus process drives inputs on the falling edge, advances an
// arithmetic reference model of the channel and pushes the outputs expected
// after the following rising edge into a queue. A monitor process pops one
// entry after each rising edge and compares it with the DUT outputs.
// ---------------------------------------------------------------------------
module tb_adc_channel_conditioner;

    localparam logic [6:0] ADDR_DCO_EN = 7'd10;
    localparam logic [6:0] ADDR_OFFSET = 7'd11;
    localparam int         DCO_BIT     = 0;

    logic        clock = 1'b0;
    logic        reset = 1'b1;
    logic        enable = 1'b0;
    logic [6:0]  serial_addr = '0;
    logic [31:0] serial_data = '0;
    logic        serial_strobe = 1'b0;
    logic [11:0] adc_raw = 12'h123;
    logic [15:0] adc_corr;
    logic [15:0] rssi;
    logic [15:0] over_count;
    logic [31:0] dco_en_reg;

    adc_channel_conditioner #(
        .ADDR_DCO_EN (ADDR_DCO_EN),
        .ADDR_OFFSET (ADDR_OFFSET),
        .DCO_BIT     (DCO_BIT)
    ) dut (
        .clock         (clock),
        .reset         (reset),
        .enable        (enable),
        .serial_addr   (serial_addr),
        .serial_data   (serial_data),
        .serial_strobe (serial_strobe),
        .adc_raw       (adc_raw),
        .adc_corr      (adc_corr),
        .rssi          (rssi),
        .over_count    (over_count),
        .dco_en_reg    (dco_en_reg)
    );

    always #5 clock = ~clock;

    typedef struct packed {
        logic [15:0] corr;
        logic [15:0] rssi;
        logic [15:0] over;
        logic [31:0] en;
    } exp_t;

    exp_t exp_q[$];
    int   checks = 0;
    int   errors = 0;

    // -----------------------------------------------------------------------
    // Reference model: plain signed arithmetic on integers.
    // -----------------------------------------------------------------------
    int          m_adc   = 0;     // registered sample as a signed value
    longint      m_integ = 0;     // integrator as a signed 32-bit value
    logic [31:0] m_en    = '0;
    longint      m_rssi  = 0;
    longint      m_over  = 0;

    function automatic longint wrap_s(input longint v, input int bits);
        longint m;
        longint t;
        m = longint'(1) << bits;
        t = v % m;
        if (t < 0) t += m;
        if (t >= m / 2) t -= m;
        return t;
    endfunction

    // Offset is the integrator divided by 2^16, truncated toward zero.
    function automatic longint model_corr();
        return wrap_s(longint'(m_adc) * 8 - m_integ / 65536, 16);
    endfunction

    function automatic exp_t model_out();
        exp_t   e;
        longint c;
        longint r;
        longint o;
        c = model_corr();
        r = m_rssi / 1024;
        o = m_over / 1024;
        e.corr = c[15:0];
        e.rssi = r[15:0];
        e.over = o[15:0];
        e.en   = m_en;
        return e;
    endfunction

    task automatic model_edge(input bit rst, input bit en, input bit stb,
                              input logic [6:0] addr, input logic [31:0] data,
                              input logic [11:0] raw);
        longint c;
        longint a;
        bit     clip;
        if (rst) begin
            m_adc = 0; m_integ = 0; m_en = '0; m_rssi = 0; m_over = 0;
            return;
        end
        c    = model_corr();
        a    = (m_adc < 0) ? -longint'(m_adc) - 1 : longint'(m_adc);
        clip = (m_adc == 2047) || (m_adc == -2048);
        if (stb && addr == ADDR_OFFSET)
            m_integ = longint'($signed(data[15:0])) * 65536;
        else if (m_en[DCO_BIT])
            m_integ = wrap_s(m_integ + c, 32);
        if (stb && addr == ADDR_DCO_EN)
            m_en = data;
        m_rssi = en ? m_rssi + a - m_rssi / 1024 : 0;
        m_over = en ? m_over + (clip ? 65535 : 0) - m_over / 1024 : 0;
        m_adc  = int'($signed(raw));
    endtask

    // -----------------------------------------------------------------------
    // Comparison helpers
    // -----------------------------------------------------------------------
    task automatic cmp(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s actual=%h required=%h", name, act, req);
        end
    endtask

    task automatic cmp_range(input string name, input int act, input int lo, input int hi);
        checks++;
        if (act < lo || act > hi) begin
            errors++;
            $display("FAIL %s actual=%0d required=%0d..%0d", name, act, lo, hi);
        end
    endtask

    // -----------------------------------------------------------------------
    // Monitor
    // -----------------------------------------------------------------------
    initial begin
        exp_t e;
        forever begin
            @(posedge clock);
            #1;
            if (exp_q.size() > 0) begin
                e = exp_q.pop_front();
                cmp("adc_corr",   {16'd0, adc_corr},   {16'd0, e.corr});
                cmp("rssi",       {16'd0, rssi},       {16'd0, e.rssi});
                cmp("over_count", {16'd0, over_count}, {16'd0, e.over});
                cmp("dco_en_reg", dco_en_reg,          e.en);
            end
        end
    end

    initial begin
        #3000000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1, "watchdog");
    end

    // -----------------------------------------------------------------------
    // Stimulus
    // -----------------------------------------------------------------------
    task automatic step(input bit rst, input bit en, input bit stb,
                        input logic [6:0] addr, input logic [31:0] data,
                        input logic [11:0] raw);
        @(negedge clock);
        reset         = rst;
        enable        = en;
        serial_strobe = stb;
        serial_addr   = addr;
        serial_data   = data;
        adc_raw       = raw;
        if (stb)
            $display("bus write addr=%0d data=%08h rst=%0d", addr, data, rst);
        model_edge(rst, en, stb, addr, data, raw);
        exp_q.push_back(model_out());
    endtask

    // Wait for the edge that consumes the last pushed expectation; call once
    // directly after a step so that no edge goes unmodelled.
    task automatic after_edge();
        @(posedge clock);
        #2;
    endtask

    task automatic check_zero_now(input string tag);
        #1;
        cmp({tag, "_corr"}, {16'd0, adc_corr},   32'd0);
        cmp({tag, "_rssi"}, {16'd0, rssi},       32'd0);
        cmp({tag, "_over"}, {16'd0, over_count}, 32'd0);
        cmp({tag, "_en"},   dco_en_reg,          32'd0);
    endtask

    function automatic logic [11:0] pick_raw();
        logic [11:0] b [4];
        int r;
        b[0] = 12'h7FF; b[1] = 12'h800; b[2] = 12'h7FE; b[3] = 12'h801;
        r = $urandom_range(0, 99);
        if (r < 6) return b[$urandom_range(0, 3)];
        return 12'($urandom);
    endfunction

    initial begin
        bit          en_r;
        bit          stb;
        logic [6:0]  addr;
        logic [31:0] data;
        int          sel;

        // Reset held from time 0 with a nonzero sample on the input.
        check_zero_now("reset_init");
        repeat (3) step(1, 0, 0, 7'd0, 32'd0, 12'h123);

        // Release: first edge captures 0x123 -> 0x918.
        step(0, 0, 0, 7'd0, 32'd0, 12'h123);
        after_edge();
        cmp("release_corr", {16'd0, adc_corr}, 32'h0918);
        cmp("release_rssi", {16'd0, rssi},     32'h0000);

        // Pass-through.
        step(0, 0, 0, 7'd0, 32'd0, 12'h100);
        after_edge();
        cmp("pass_corr", {16'd0, adc_corr}, 32'h0800);

        // Offset loads.
        step(0, 0, 1, ADDR_OFFSET, 32'h0000_0100, 12'h100);
        after_edge();
        cmp("load_pos_corr", {16'd0, adc_corr}, 32'h0700);
        step(0, 0, 1, ADDR_OFFSET, 32'h0000_FF00, 12'h100);
        after_edge();
        cmp("load_neg_corr", {16'd0, adc_corr}, 32'h0900);
        step(0, 0, 1, ADDR_OFFSET + 7'd1, 32'h0000_1234, 12'h100);
        after_edge();
        cmp("other_addr_corr", {16'd0, adc_corr}, 32'h0900);
        repeat (20) step(0, 0, 0, 7'd0, 32'd0, 12'h100);

        // DC loop from a clean integrator.
        step(0, 0, 1, ADDR_OFFSET, 32'd0, 12'h100);
        step(0, 0, 1, ADDR_DCO_EN, 32'd1 << DCO_BIT, 12'h100);
        step(0, 0, 0, 7'd0, 32'd0, 12'h100);
        after_edge();
        cmp("dc_first_corr", {16'd0, adc_corr}, 32'h0800);
        repeat (6000) step(0, 0, 0, 7'd0, 32'd0, 12'h100);
        step(0, 0, 1, ADDR_DCO_EN, 32'd0, 12'h100);
        repeat (200) step(0, 0, 0, 7'd0, 32'd0, 12'h100);

        // Randomized traffic: address/data toggle freely, strobes are rare.
        en_r = 1'b1;
        for (int i = 0; i < 4000; i++) begin
            if ($urandom_range(0, 199) == 0) en_r = ~en_r;
            stb  = ($urandom_range(0, 49) == 0);
            sel  = $urandom_range(0, 2);
            addr = (sel == 0) ? ADDR_DCO_EN : (sel == 1) ? ADDR_OFFSET : 7'($urandom);
            data = $urandom;
            step(0, en_r, stb, addr, data, pick_raw());
        end

        // RSSI convergence on a constant negative sample (magnitude 0xFF).
        step(0, 0, 1, ADDR_DCO_EN, 32'd0, 12'hF00);
        repeat (20000) step(0, 1, 0, 7'd0, 32'd0, 12'hF00);
        after_edge();
        cmp_range("rssi_settled", int'(rssi), 254, 256);
        step(0, 0, 0, 7'd0, 32'd0, 12'hF00);
        after_edge();
        cmp("rssi_cleared", {16'd0, rssi}, 32'd0);

        // Continuous clipping on both rails, then decay.
        for (int i = 0; i < 20000; i++)
            step(0, 1, 0, 7'd0, 32'd0, (i % 2 == 0) ? 12'h7FF : 12'h800);
        after_edge();
        cmp_range("over_settled", int'(over_count), 65534, 65535);
        repeat (3000) step(0, 1, 0, 7'd0, 32'd0, 12'h000);

        // Reset mid-operation together with an offset load.
        step(0, 1, 1, ADDR_DCO_EN, 32'hFFFF_FFFF, 12'h7FF);
        repeat (10) step(0, 1, 0, 7'd0, 32'd0, 12'h355);
        step(1, 1, 1, ADDR_OFFSET, 32'h0000_7FFF, 12'h355);
        check_zero_now("reset_mid");
        step(0, 1, 0, 7'd0, 32'd0, 12'h355);
        for (int i = 0; i < 200; i++)
            step(0, 1, ($urandom_range(0, 19) == 0), ADDR_OFFSET, $urandom, pick_raw());

        // Drain the scoreboard.
        repeat (3) @(posedge clock);
        #3;
        cmp("scoreboard_drain", exp_q.size(), 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
